// File: rtl/fdsync_dbuf.sv
// fdsync_dbuf: double-buffered, lane-writable sync register.
// Bus writes land in a shadow register with per-lane enables. A commit
// strobe copies the shadow into the active register in one edge, so a
// multi-lane update reaches the pipeline atomically. The block also
// tracks which lanes are pending, flags lanes that are written twice
// before a commit (sticky overrun), and pulses upd after a commit that
// carried new data.
module fdsync_dbuf #(
  parameter int                 WIDTH     = 24,
  parameter int                 LANES     = 3,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   d,
  input  logic               ld,
  input  logic [LANES-1:0]   lane_en,
  input  logic               xfer,
  input  logic               clr_ovr,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   shadow,
  output logic [LANES-1:0]   pend,
  output logic               ovr,
  output logic               upd
);

  localparam int LW = WIDTH / LANES;

  // State registers; every output is driven straight from one of these.
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] shadow_r;
  logic [LANES-1:0] pend_r;
  logic             ovr_r;
  logic             upd_r;

  // Combinational next-state terms.
  logic [LANES-1:0] lane_wr_s;      // lanes actually written this edge
  logic [WIDTH-1:0] next_shadow_s;  // shadow with this edge's write merged in
  logic             ovr_set_s;      // a pending lane is rewritten without commit
  logic             commit_data_s;  // this commit carries new data

  // Qualify the per-lane enables with the write strobe.
  always_comb begin
    lane_wr_s = {LANES{1'b0}};
    if (ld) begin
      lane_wr_s = lane_en;
    end else begin
      lane_wr_s = {LANES{1'b0}};
    end
  end

  // Merge the written lanes over the current shadow; a commit on the same
  // edge takes this merged value, giving the ld+xfer write-through.
  always_comb begin
    next_shadow_s = shadow_r;
    for (int k = 0; k < LANES; k++) begin
      if (lane_wr_s[k]) begin
        next_shadow_s[k*LW +: LW] = d[k*LW +: LW];
      end else begin
        next_shadow_s[k*LW +: LW] = shadow_r[k*LW +: LW];
      end
    end
  end

  // Overrun and commit-content detection. A write that is committed on the
  // same edge is never an overrun, since nothing pending gets lost.
  always_comb begin
    ovr_set_s     = 1'b0;
    commit_data_s = 1'b0;
    if (!xfer) begin
      ovr_set_s = |(lane_wr_s & pend_r);
    end else begin
      ovr_set_s = 1'b0;
    end
    commit_data_s = (|pend_r) | (|lane_wr_s);
  end

  // Shadow register: absorbs every accepted lane write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= RESET_VAL;
    end else begin
      shadow_r <= next_shadow_s;
    end
  end

  // Active register: loads the merged shadow on a commit. With nothing
  // pending shadow already equals q, so an idle commit leaves q unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= RESET_VAL;
    end else if (xfer) begin
      q_r <= next_shadow_s;
    end else begin
      q_r <= q_r;
    end
  end

  // Pending lanes: set by writes, cleared wholesale by a commit (including
  // lanes written on the commit edge itself).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= {LANES{1'b0}};
    end else if (xfer) begin
      pend_r <= {LANES{1'b0}};
    end else begin
      pend_r <= pend_r | lane_wr_s;
    end
  end

  // Sticky overrun flag; a set on the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_r <= 1'b0;
    end else if (ovr_set_s) begin
      ovr_r <= 1'b1;
    end else if (clr_ovr) begin
      ovr_r <= 1'b0;
    end else begin
      ovr_r <= ovr_r;
    end
  end

  // Commit pulse: high for the one cycle after a commit that moved data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_r <= 1'b0;
    end else begin
      upd_r <= xfer & commit_data_s;
    end
  end

  assign q      = q_r;
  assign shadow = shadow_r;
  assign pend   = pend_r;
  assign ovr    = ovr_r;
  assign upd    = upd_r;

endmodule

// File: tb/tb_fdsync_dbuf.sv
// Self-checking bench for fdsync_dbuf: directed scenarios followed by
// random traffic, all compared against a lane-level reference model.
module tb_fdsync_dbuf;

  localparam int              W    = 24;
  localparam int              L    = 3;
  localparam int              LW   = W / L;
  localparam logic [W-1:0]    RVAL = 24'h123456;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  d;
  logic          ld;
  logic [L-1:0]  lane_en;
  logic          xfer;
  logic          clr_ovr;
  logic [W-1:0]  q;
  logic [W-1:0]  shadow;
  logic [L-1:0]  pend;
  logic          ovr;
  logic          upd;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [W-1:0] m_q;
  logic [W-1:0] m_sh;
  logic [L-1:0] m_pend;
  logic         m_ovr;
  logic         m_upd;

  fdsync_dbuf #(.WIDTH(W), .LANES(L), .RESET_VAL(RVAL)) dut (
    .clk(clk), .reset(reset), .d(d), .ld(ld), .lane_en(lane_en),
    .xfer(xfer), .clr_ovr(clr_ovr), .q(q), .shadow(shadow),
    .pend(pend), .ovr(ovr), .upd(upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},      q,                  m_q);
    check({tag, ".shadow"}, shadow,             m_sh);
    check({tag, ".pend"},   {{(W-L){1'b0}}, pend}, {{(W-L){1'b0}}, m_pend});
    check({tag, ".ovr"},    {{(W-1){1'b0}}, ovr},  {{(W-1){1'b0}}, m_ovr});
    check({tag, ".upd"},    {{(W-1){1'b0}}, upd},  {{(W-1){1'b0}}, m_upd});
  endtask

  task automatic model_reset();
    m_q = RVAL; m_sh = RVAL; m_pend = '0; m_ovr = 1'b0; m_upd = 1'b0;
  endtask

  // One rising edge of the register as described behaviourally.
  task automatic model_edge(input logic l, input logic [L-1:0] en, input logic [W-1:0] dd,
                            input logic x, input logic c);
    logic had_pend, wrote, set;
    had_pend = (m_pend != '0);
    wrote = 1'b0;
    set = 1'b0;
    for (int k = 0; k < L; k++) begin
      if (l && en[k]) begin
        if (!x && m_pend[k]) set = 1'b1;
        m_sh[k*LW +: LW] = dd[k*LW +: LW];
        m_pend[k] = 1'b1;
        wrote = 1'b1;
      end
    end
    m_upd = x && (had_pend || wrote);
    if (x) begin
      m_q = m_sh;
      m_pend = '0;
    end
    if (set) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
  endtask

  // Drive inputs (caller sits just after an edge), clock, update model, check.
  task automatic step(input string tag, input logic l, input logic [L-1:0] en,
                      input logic [W-1:0] dd, input logic x, input logic c);
    ld = l; lane_en = en; d = dd; xfer = x; clr_ovr = c;
    @(posedge clk);
    model_edge(l, en, dd, x, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; d = '0; ld = 1'b0; lane_en = '0; xfer = 1'b0; clr_ovr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_q_const", q, 24'h123456);
    reset = 1'b0;

    // Write lanes 0 and 2, then commit
    step("wr101", 1'b1, 3'b101, 24'hAABBCC, 1'b0, 1'b0);
    check("wr101_shadow", shadow, 24'hAA34CC);
    check("wr101_q_hold", q, 24'h123456);
    step("commit", 1'b0, 3'b000, 24'h0, 1'b1, 1'b0);
    check("commit_q", q, 24'hAA34CC);
    check("commit_upd", {23'd0, upd}, 24'd1);
    step("after_commit", 1'b0, 3'b000, 24'h0, 1'b0, 1'b0);
    check("upd_one_cycle", {23'd0, upd}, 24'd0);

    // Zero q via write-through, then lane-1 write-through
    step("zero_wt", 1'b1, 3'b111, 24'h000000, 1'b1, 1'b0);
    step("wt010", 1'b1, 3'b010, 24'h00EE00, 1'b1, 1'b0);
    check("wt010_q", q, 24'h00EE00);
    check("wt010_ovr", {23'd0, ovr}, 24'd0);

    // Overrun sequence
    step("ovr_w1", 1'b1, 3'b001, 24'h000011, 1'b0, 1'b0);
    step("ovr_w2", 1'b1, 3'b001, 24'h000022, 1'b0, 1'b0);
    check("ovr_set", {23'd0, ovr}, 24'd1);
    check("ovr_shadow", shadow, 24'h00EE22);
    step("ovr_clr", 1'b0, 3'b000, 24'h0, 1'b0, 1'b1);
    check("ovr_cleared", {23'd0, ovr}, 24'd0);
    step("ovr_setwins", 1'b1, 3'b001, 24'h000033, 1'b0, 1'b1);
    check("ovr_set_wins", {23'd0, ovr}, 24'd1);

    // Commit, then back-to-back idle commit
    step("commit2", 1'b0, 3'b000, 24'h0, 1'b1, 1'b0);
    check("commit2_q", q, 24'h00EE33);
    step("idle_xfer", 1'b0, 3'b000, 24'h0, 1'b1, 1'b0);
    check("idle_upd", {23'd0, upd}, 24'd0);
    check("idle_q", q, 24'h00EE33);
    step("clr", 1'b0, 3'b000, 24'h0, 1'b0, 1'b1);

    // Reset mid-sequence with lanes pending
    step("pend011", 1'b1, 3'b011, 24'h55AA77, 1'b0, 1'b0);
    check("pend011_pend", {21'd0, pend}, 24'd3);
    ld = 1'b0; lane_en = '0; xfer = 1'b0; clr_ovr = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_reset_edge");
    step("xfer_after_reset", 1'b0, 3'b000, 24'h0, 1'b1, 1'b0);
    check("xfer_after_reset_upd", {23'd0, upd}, 24'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rnd_reset");
        reset = 1'b0;
      end else begin
        step("rnd",
             ($urandom_range(0, 2) != 0),
             3'($urandom_range(0, 7)),
             24'($urandom),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
